// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: ALU operation
// codes (matching decode) and the FSM state encoding.
package muldiv_pkg;

  localparam logic [2:0] ALU_MUL  = 3'b111;
  localparam logic [2:0] ALU_SMUL = 3'b110;
  localparam logic [2:0] ALU_UMUL = 3'b101;
  localparam logic [2:0] ALU_DIV  = 3'b100;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  function automatic logic op_valid(input logic [2:0] code);
    return code inside {ALU_MUL, ALU_SMUL, ALU_UMUL, ALU_DIV};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide coprocessor: shift-add multiply (LSB first) and
// restoring divide (MSB first), one bit per cycle, WIDTH cycles per operation.
//
// state  | meaning
// IDLE   | waiting for Start with a valid code; results hold
// RUN    | iterating; counter counts WIDTH-1 down to 0
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             HiWE,
  output logic             DivZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             sneg_q, sneg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             hiwe_q, hiwe_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [2*WIDTH-1:0] prod, prod_final;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH:0]     rem_n;
  logic [WIDTH-1:0]   q_n;
  logic               is_div;

  assign mag_a = (ALUControl == ALU_SMUL && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign mag_b = (ALUControl == ALU_SMUL && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  assign is_div = (op_q == ALU_DIV);

  // Multiply: hi accumulates the multiplicand, lo shifts out multiplier bits.
  assign mul_sum    = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi_n   = mul_sum[WIDTH:1];
  assign mul_lo_n   = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign prod       = {mul_hi_n, mul_lo_n};
  assign prod_final = (op_q == ALU_SMUL && sneg_q) ? -prod : prod;

  // Divide: the top bit of the trial difference is the borrow (restore when set).
  assign div_diff = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, b_q};
  assign div_ge   = ~div_diff[WIDTH+1];
  assign rem_n    = div_ge ? div_diff[WIDTH:0] : {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign q_n      = {lo_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sneg_d   = sneg_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    hiwe_d   = hiwe_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (Start && op_valid(ALUControl)) begin
          state_d = S_RUN;
          op_d    = ALUControl;
          sneg_d  = (ALUControl == ALU_SMUL) && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          cnt_d   = CW'(WIDTH - 1);
          hi_d    = '0;
          if (ALUControl == ALU_DIV) begin
            b_d  = SrcB;
            lo_d = SrcA;
          end else begin
            b_d  = mag_a;
            lo_d = mag_b;
          end
        end
      end
      default: begin
        hi_d  = is_div ? rem_n : {1'b0, mul_hi_n};
        lo_d  = is_div ? q_n : mul_lo_n;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          done_d   = 1'b1;
          res_lo_d = is_div ? q_n : prod_final[WIDTH-1:0];
          res_hi_d = is_div ? rem_n[WIDTH-1:0] : prod_final[2*WIDTH-1:WIDTH];
          hiwe_d   = (op_q != ALU_MUL);
          dz_d     = is_div && (b_q == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sneg_q   <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      hiwe_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sneg_q   <= sneg_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      hiwe_q   <= hiwe_d;
      dz_q     <= dz_d;
    end
  end

  assign Busy     = (state_q == S_RUN);
  assign Done     = done_q;
  assign ResultLo = res_lo_q;
  assign ResultHi = res_hi_q;
  assign HiWE     = hiwe_q;
  assign DivZero  = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: expected results are queued at
// issue time and compared when Done is observed.
module tb_muldiv_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         hiwe;
    logic         dz;
    int           due;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA, SrcB;
  logic         Busy, Done, HiWE, DivZero;
  logic [W-1:0] ResultLo, ResultHi;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .HiWE(HiWE), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", 64'(Done), 64'd0);
      if (Done) begin
        check("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_lo"}, 64'(ResultLo), 64'(e.lo));
          check({e.tag, "_hi"}, 64'(ResultHi), 64'(e.hi));
          check({e.tag, "_hiwe"}, 64'(HiWE), 64'(e.hiwe));
          check({e.tag, "_divzero"}, 64'(DivZero), 64'(e.dz));
          check({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
          check({e.tag, "_busy_at_done"}, 64'(Busy), 64'd0);
        end
      end
      prev_done = Done;
    end
  end

  // Called at a negedge; returns one negedge later with Start deasserted.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic ehiwe, input logic edz, input string tag);
    exp_t e;
    Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    e.lo = elo; e.hi = ehi; e.hiwe = ehiwe; e.dz = edz; e.tag = tag;
    e.due = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b0;
    check({tag, "_busy"}, 64'(Busy), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
    check({tag, "_done"}, 64'(Done), 64'd0);
    check({tag, "_lo"}, 64'(ResultLo), 64'd0);
    check({tag, "_hi"}, 64'(ResultHi), 64'd0);
    check({tag, "_hiwe"}, 64'(HiWE), 64'd0);
    check({tag, "_divzero"}, 64'(DivZero), 64'd0);
  endtask

  initial begin
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] p;
    int             n;

    reset = 1'b1; Start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0, "umul_max");
    drain("umul_max");
    issue(3'b110, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0, "smul_neg");
    drain("smul_neg");
    issue(3'b110, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, 1'b0, "smul_min");
    drain("smul_min");
    issue(3'b111, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, "mul_low");
    drain("mul_low");
    issue(3'b100, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0, "div_100_7");
    drain("div_100_7");
    issue(3'b100, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b1, "div_zero");
    drain("div_zero");

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      p = {32'd0, ra} * {32'd0, rb};
      issue(3'b101, ra, rb, p[63:32], p[31:0], 1'b1, 1'b0, "umul_rand");
      drain("umul_rand");
      p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      issue(3'b110, ra, rb, p[63:32], p[31:0], 1'b1, 1'b0, "smul_rand");
      drain("smul_rand");
      rb = ($urandom % 32'h0001_0000) + 1;
      issue(3'b100, ra, rb, ra % rb, ra / rb, 1'b1, 1'b0, "div_rand");
      drain("div_rand");
    end

    // Start pulsed mid-operation with different operands must be ignored
    issue(3'b101, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b1, 1'b0, "mid_start");
    repeat (5) @(negedge clk);
    Start = 1'b1; ALUControl = 3'b100; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    drain("mid_start");

    // Invalid code: no Busy, no Done, results unchanged
    Start = 1'b1; ALUControl = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk);
    Start = 1'b0;
    check("invalid_busy", 64'(Busy), 64'd0);
    repeat (W + 8) @(negedge clk);
    check("invalid_lo_held", 64'(ResultLo), 64'h23456780);
    check("invalid_hi_held", 64'(ResultHi), 64'h1);

    // Back-to-back: second Start driven in the Done cycle
    issue(3'b101, 32'd7, 32'd9, 32'd0, 32'd63, 1'b1, 1'b0, "b2b_first");
    n = 0;
    while (!Done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 64'(Done), 64'd1);
    issue(3'b100, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b1, 1'b0, "b2b_second");
    drain("b2b");

    // Reset at iteration 10 of a DIV
    issue(3'b100, 32'h0000FFFF, 32'd3, 32'd0, 32'h00005555, 1'b1, 1'b0, "div_reset");
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 8) @(negedge clk);
    check("post_reset_idle", 64'(Busy), 64'd0);
    issue(3'b101, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, 1'b0, "umul_after_reset");
    drain("umul_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
